// File: rtl/nx_fifo_rd_stage.sv
// nx_fifo_rd_stage: pops a show-ahead FIFO into a registered valid/ready stream through a 2-entry prefetch buffer
module nx_fifo_rd_stage #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             fifo_ren,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] xfer_cnt
);
  logic [1:0] occ, occ_nx;
  logic [WIDTH-1:0] head, skid, head_nx, skid_nx;
  logic [CNT_W-1:0] cnt;
  logic pop, push;
  always_ff @(posedge clk)
    if (rst) begin
      occ  <= '0;
      head <= '0;
      skid <= '0;
      cnt  <= '0;
    end else begin
      occ  <= occ_nx;
      head <= head_nx;
      skid <= skid_nx;
      cnt  <= cnt + CNT_W'(pop);
    end
  always_comb begin
    occ_nx  = clear ? 2'd0 : occ + {1'b0, push} - {1'b0, pop};
    head_nx = (push & (occ == 2'd0 | (occ == 2'd1 & pop))) ? fifo_rdata :
              (pop & occ == 2'd2) ? skid : head;
    skid_nx = (push & ((occ == 2'd1 & !pop) | (occ == 2'd2 & pop))) ? fifo_rdata : skid;
  end
  // pop is masked by clear so a flush cycle never counts or shifts data
  always_comb begin
    out_valid = occ != 2'd0;
    pop       = out_valid & out_ready & !clear;
    fifo_ren  = !fifo_empty & !clear & !rst & (!occ[1] | pop);
    push      = fifo_ren;
    out_data  = head;
    occupancy = occ;
    xfer_cnt  = cnt;
  end
endmodule
